gpio_ctrl: RTL and testbench

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_ctrl_pkg.sv | 45 ++++
 rtl/gpio_ctrl_if.sv | 22 ++
 rtl/gpio_sync_edge.sv | 34 +++
 rtl/gpio_ctrl.sv | 105 ++++++++++
 tb/tb_gpio_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO block: default width, register offsets and bus helpers.
// Also used by the address decoder documentation and the testbench.
package gpio_ctrl_pkg;

    localparam int GPIO_WIDTH_DEFAULT = 32;

    localparam logic [11:0] OFF_DATA_OUT   = 12'h000;
    localparam logic [11:0] OFF_DIR        = 12'h004;
    localparam logic [11:0] OFF_DATA_IN    = 12'h008;
    localparam logic [11:0] OFF_IRQ_EN     = 12'h00C;
    localparam logic [11:0] OFF_EDGE_SEL   = 12'h010;
    localparam logic [11:0] OFF_IRQ_STATUS = 12'h014;

    typedef enum logic [2:0] {
        SEL_DATA_OUT,
        SEL_DIR,
        SEL_DATA_IN,
        SEL_IRQ_EN,
        SEL_EDGE_SEL,
        SEL_IRQ_STATUS,
        SEL_NONE
    } reg_sel_e;

    // Word-level decode; the byte lane bits of the offset never take part.
    function automatic reg_sel_e decode_addr(input logic [9:0] word_addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word_addr == OFF_DATA_OUT[11:2])   sel = SEL_DATA_OUT;
        if (word_addr == OFF_DIR[11:2])        sel = SEL_DIR;
        if (word_addr == OFF_DATA_IN[11:2])    sel = SEL_DATA_IN;
        if (word_addr == OFF_IRQ_EN[11:2])     sel = SEL_IRQ_EN;
        if (word_addr == OFF_EDGE_SEL[11:2])   sel = SEL_EDGE_SEL;
        if (word_addr == OFF_IRQ_STATUS[11:2]) sel = SEL_IRQ_STATUS;
        return sel;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_ctrl_if.sv
// Memory-mapped bus between the address decoder / CPU side and the GPIO block.
interface gpio_ctrl_if;

    logic        cs_gpio_n;
    logic [11:0] Addr;
    logic        MemWrite;
    logic        MemRead;
    logic [3:0]  ByteEnable;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output cs_gpio_n, Addr, MemWrite, MemRead, ByteEnable, WriteData,
        input  ReadData
    );

    modport slave (
        input  cs_gpio_n, Addr, MemWrite, MemRead, ByteEnable, WriteData,
        output ReadData
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// Per-pin 2-flop synchronizer plus a history stage for rise/fall detection.
// Stages reset to 0, so a pin held high through reset reports one rising edge.
module gpio_sync_edge #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_level = r_sync2;
    assign o_rise  = r_sync2 & ~r_prev;
    assign o_fall  = ~r_sync2 & r_prev;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: output/direction registers, synchronized inputs and
// edge-triggered interrupt status (W1C) with a registered level irq.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int WIDTH = GPIO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    gpio_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_edge_sel;
    logic [WIDTH-1:0] r_irq_status;
    logic [31:0]      r_read_data;
    logic             r_irq;

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wmask;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_bmask32;
    logic [31:0]      w_rdata;
    logic             w_wr;
    logic             w_rd;
    logic [1:0]       w_unused_addr;
    reg_sel_e         w_sel;

    gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .i_async (gpio_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_wr          = ~bus.cs_gpio_n & bus.MemWrite;
    assign w_rd          = ~bus.cs_gpio_n & bus.MemRead;
    assign w_sel         = decode_addr(bus.Addr[11:2]);
    assign w_unused_addr = bus.Addr[1:0];
    assign w_bmask32     = byte_mask(bus.ByteEnable);
    assign w_wmask       = w_bmask32[WIDTH-1:0];
    assign w_wdata       = bus.WriteData[WIDTH-1:0];

    // Set has priority over a same-cycle W1C because it is OR-ed in after the clear.
    assign w_set = (w_rise & r_edge_sel) | (w_fall & ~r_edge_sel);
    assign w_clr = (w_wr && w_sel == SEL_IRQ_STATUS) ? (w_wdata & w_wmask) : '0;

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            SEL_DATA_OUT:   w_rdata = 32'(r_data_out);
            SEL_DIR:        w_rdata = 32'(r_dir);
            SEL_DATA_IN:    w_rdata = 32'(w_level);
            SEL_IRQ_EN:     w_rdata = 32'(r_irq_en);
            SEL_EDGE_SEL:   w_rdata = 32'(r_edge_sel);
            SEL_IRQ_STATUS: w_rdata = 32'(r_irq_status);
            default:        w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out   <= '0;
            r_dir        <= '0;
            r_irq_en     <= '0;
            r_edge_sel   <= '0;
            r_irq_status <= '0;
            r_read_data  <= '0;
            r_irq        <= 1'b0;
        end else begin
            if (w_wr) begin
                case (w_sel)
                    SEL_DATA_OUT: r_data_out <= (r_data_out & ~w_wmask) | (w_wdata & w_wmask);
                    SEL_DIR:      r_dir      <= (r_dir      & ~w_wmask) | (w_wdata & w_wmask);
                    SEL_IRQ_EN:   r_irq_en   <= (r_irq_en   & ~w_wmask) | (w_wdata & w_wmask);
                    SEL_EDGE_SEL: r_edge_sel <= (r_edge_sel & ~w_wmask) | (w_wdata & w_wmask);
                    default:      ;
                endcase
            end
            if (w_rd) begin
                r_read_data <= w_rdata;
            end
            r_irq_status <= (r_irq_status & ~w_clr) | w_set;
            r_irq        <= |(r_irq_status & r_irq_en);
        end
    end

    assign bus.ReadData = r_read_data;
    assign gpio_out     = r_data_out;
    assign gpio_oe      = r_dir;
    assign irq          = r_irq;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: a register-access vector table plus hand-written
// sequences for synchronizer latency, W1C/set priority and asynchronous reset.
module tb_gpio_ctrl;
    import gpio_ctrl_pkg::*;

    typedef struct {
        string       name;
        logic        csN;
        logic        wr;
        logic        rd;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chkRd;
        logic [31:0] expRd;
        logic [31:0] expOut;
        logic [31:0] expOe;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;
    logic [31:0] rdVal;

    int   testsRun;
    int   testsFailed;
    vec_t vecs[$];

    gpio_ctrl_if bus ();

    gpio_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic busIdle();
        bus.cs_gpio_n  = 1'b1;
        bus.MemWrite   = 1'b0;
        bus.MemRead    = 1'b0;
        bus.Addr       = '0;
        bus.ByteEnable = '0;
        bus.WriteData  = '0;
    endtask

    // One bus cycle: drive on the falling edge, return 1 ns after the rising edge.
    task automatic applyStimulus(input logic csN, input logic wr, input logic rd, input logic [11:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        @(negedge clk);
        bus.cs_gpio_n  = csN;
        bus.MemWrite   = wr;
        bus.MemRead    = rd;
        bus.Addr       = addr;
        bus.ByteEnable = be;
        bus.WriteData  = wdata;
        @(posedge clk);
        #1;
        busIdle();
    endtask

    task automatic busWrite(input logic [11:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        applyStimulus(1'b0, 1'b1, 1'b0, addr, be, wdata);
    endtask

    task automatic busRead(input logic [11:0] addr, output logic [31:0] data);
        applyStimulus(1'b0, 1'b0, 1'b1, addr, 4'h0, 32'h0);
        data = bus.ReadData;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic addVec(input string n, input logic csN, input logic wr, input logic rd,
                          input logic [11:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                          input logic chkRd, input logic [31:0] expRd,
                          input logic [31:0] expOut, input logic [31:0] expOe);
        vec_t v;
        v.name = n; v.csN = csN; v.wr = wr; v.rd = rd; v.addr = addr; v.be = be;
        v.wdata = wdata; v.chkRd = chkRd; v.expRd = expRd; v.expOut = expOut; v.expOe = expOe;
        vecs.push_back(v);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        gpio_in     = '0;
        busIdle();
        reset = 1'b1;
        #1;
        checkOutput("reset gpio_out", gpio_out, 32'h0);
        checkOutput("reset gpio_oe", gpio_oe, 32'h0);
        checkOutput("reset irq", {31'h0, irq}, 32'h0);
        checkOutput("reset ReadData", bus.ReadData, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        //     name                 csN  wr  rd  addr    be     wdata         chk rdExp         out           oe
        addVec("byte1 write",       0,   1,  0,  12'h000, 4'h2, 32'h12345678, 0, 32'h0,        32'h00005600, 32'h0);
        addVec("dir write",         0,   1,  0,  12'h004, 4'hF, 32'h0000FFFF, 0, 32'h0,        32'h00005600, 32'h0000FFFF);
        addVec("data_out write",    0,   1,  0,  12'h000, 4'hF, 32'hA5A5A5A5, 0, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF);
        addVec("data_out read",     0,   0,  1,  12'h000, 4'h0, 32'h0,        1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0000FFFF);
        addVec("dir read",          0,   0,  1,  12'h004, 4'h0, 32'h0,        1, 32'h0000FFFF, 32'hA5A5A5A5, 32'h0000FFFF);
        addVec("deselected write",  1,   1,  0,  12'h000, 4'hF, 32'hFFFFFFFF, 0, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF);
        addVec("deselected read",   1,   0,  1,  12'h000, 4'h0, 32'h0,        1, 32'h0000FFFF, 32'hA5A5A5A5, 32'h0000FFFF);
        addVec("unmapped 0FC read", 0,   0,  1,  12'h0FC, 4'h0, 32'h0,        1, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF);
        addVec("data_in write",     0,   1,  0,  12'h008, 4'hF, 32'hFFFFFFFF, 0, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF);
        addVec("data_in read",      0,   0,  1,  12'h008, 4'h0, 32'h0,        1, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF);
        addVec("irq_en rd+wr",      0,   1,  1,  12'h00C, 4'hF, 32'hDEADBEEF, 1, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF);
        addVec("irq_en read",       0,   0,  1,  12'h00E, 4'h0, 32'h0,        1, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0000FFFF);
        addVec("irq_en clear",      0,   1,  0,  12'h00C, 4'hF, 32'h0,        0, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF);
        addVec("edge_sel byte0",    0,   1,  0,  12'h010, 4'h1, 32'h00000FF0, 0, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF);
        addVec("edge_sel read",     0,   0,  1,  12'h010, 4'h0, 32'h0,        1, 32'h000000F0, 32'hA5A5A5A5, 32'h0000FFFF);
        addVec("unmapped write",    0,   1,  0,  12'h100, 4'hF, 32'hFFFFFFFF, 0, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF);
        addVec("unmapped read",     0,   0,  1,  12'h100, 4'h0, 32'h0,        1, 32'h0,        32'hA5A5A5A5, 32'h0000FFFF);
        addVec("byte3 clear",       0,   1,  0,  12'h000, 4'h8, 32'h0,        0, 32'h0,        32'h00A5A5A5, 32'h0000FFFF);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].csN, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].be, vecs[i].wdata);
            checkOutput({vecs[i].name, " gpio_out"}, gpio_out, vecs[i].expOut);
            checkOutput({vecs[i].name, " gpio_oe"}, gpio_oe, vecs[i].expOe);
            if (vecs[i].chkRd) begin
                checkOutput({vecs[i].name, " ReadData"}, bus.ReadData, vecs[i].expRd);
            end
        end

        // Rising edge on pin 0: status lands on the 3rd edge, irq on the 4th.
        doReset();
        busWrite(OFF_EDGE_SEL, 32'h1, 4'hF);
        busWrite(OFF_IRQ_EN, 32'h1, 4'hF);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rise irq before latency", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rise irq asserted", {31'h0, irq}, 32'h1);
        busRead(OFF_IRQ_STATUS, rdVal);
        checkOutput("rise status", rdVal, 32'h1);
        busRead(OFF_DATA_IN, rdVal);
        checkOutput("data_in pin0", rdVal, 32'h1);
        busWrite(OFF_IRQ_STATUS, 32'h1, 4'hF);
        checkOutput("w1c irq still high", {31'h0, irq}, 32'h1);
        @(posedge clk);
        #1;
        checkOutput("w1c irq low", {31'h0, irq}, 32'h0);
        busRead(OFF_IRQ_STATUS, rdVal);
        checkOutput("w1c status cleared", rdVal, 32'h0);

        // Pin 3 held high through reset: one rise, ignored since EDGE_SEL is falling.
        @(negedge clk);
        reset   = 1'b1;
        gpio_in = 32'h8;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        busWrite(OFF_IRQ_EN, 32'h8, 4'hF);
        busWrite(OFF_DATA_OUT, 32'hFFFF0000, 4'hF);
        busWrite(OFF_DIR, 32'h0000FF00, 4'hF);
        repeat (2) @(posedge clk);
        busRead(OFF_DATA_IN, rdVal);
        checkOutput("data_in pin3 high", rdVal, 32'h8);
        busRead(OFF_IRQ_STATUS, rdVal);
        checkOutput("rise ignored on falling sel", rdVal, 32'h0);

        // Falling edge on pin 3 coincident with a W1C of bit 3: set wins.
        @(negedge clk);
        gpio_in[3] = 1'b0;
        repeat (2) @(posedge clk);
        busWrite(OFF_IRQ_STATUS, 32'h8, 4'hF);
        busRead(OFF_IRQ_STATUS, rdVal);
        checkOutput("set beats w1c", rdVal, 32'h8);
        checkOutput("fall irq high", {31'h0, irq}, 32'h1);

        // Reset mid-write with irq high: everything clears before any clock edge.
        @(negedge clk);
        bus.cs_gpio_n  = 1'b0;
        bus.MemWrite   = 1'b1;
        bus.Addr       = OFF_DATA_OUT;
        bus.ByteEnable = 4'hF;
        bus.WriteData  = 32'h12345678;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset gpio_out", gpio_out, 32'h0);
        checkOutput("async reset gpio_oe", gpio_oe, 32'h0);
        checkOutput("async reset irq", {31'h0, irq}, 32'h0);
        checkOutput("async reset ReadData", bus.ReadData, 32'h0);
        busIdle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        busRead(OFF_DATA_OUT, rdVal);
        checkOutput("aborted write not applied", rdVal, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
